// File: rtl/matrix_pkg.sv
// Shared types and sizing helpers for the tiled matrix multiply-accumulate.
package matrix_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } mmac_state_t;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Index width that stays legal for a dimension of one.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/counter_mod.sv
// Modulo counter with synchronous clear.
// last flags the terminal count; an increment there wraps to zero.
module counter_mod
  import matrix_pkg::*;
#(
  parameter int MOD = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   inc,
  output logic [idx_w(MOD)-1:0]  count,
  output logic                   last
);

  localparam int CW = idx_w(MOD);

  assign last = (count == CW'(MOD - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc) begin
      count <= last ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/vector_chunk_select.sv
// Picks chunk t (K lanes) out of a P-lane vector.
// Lanes past P read as zero and are masked off.
module vector_chunk_select
  import matrix_pkg::*;
#(
  parameter int P     = 8,
  parameter int K     = 4,
  parameter int WIDTH = 32
) (
  input  logic [P*WIDTH-1:0]                 vec,
  input  logic [idx_w(ceil_div(P, K))-1:0]   t,
  output logic [K*WIDTH-1:0]                 chunk,
  output logic [K-1:0]                       enable
);

  localparam int T  = ceil_div(P, K);
  localparam int CW = K * WIDTH;
  localparam int PW = T * CW;
  localparam int REM = P % K;
  localparam logic [K-1:0] ONES = '1;
  localparam logic [K-1:0] TAIL =
    (REM == 0) ? ONES : (ONES >> (K - REM));

  logic [PW-1:0] padded;
  logic [PW-1:0] shifted;

  always_comb begin
    padded = '0;
    padded[P*WIDTH-1:0] = vec;
  end

  assign shifted = padded >> (int'(t) * CW);
  assign chunk   = shifted[CW-1:0];
  assign enable  = (int'(t) == T - 1) ? TAIL : ONES;

endmodule

// File: rtl/matrix_mac_tiled.sv
// X = A*B or X += A*B, one element at a time, with each dot product
// split into ceil(P/K) chunks chained through the ALU addend.
module matrix_mac_tiled
  import matrix_pkg::*;
#(
  parameter int N     = 4,
  parameter int P     = 8,
  parameter int M     = 3,
  parameter int K     = 4,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   accumulate,
  output logic                   busy,
  output logic                   finished,
  output logic [idx_w(N)-1:0]    a_row_addr,
  output logic                   a_row_addr_ready,
  input  logic                   a_row_valid,
  input  logic [P*WIDTH-1:0]     a_row_out,
  output logic [idx_w(M)-1:0]    b_col_addr,
  output logic                   b_col_addr_ready,
  input  logic                   b_col_valid,
  input  logic [P*WIDTH-1:0]     b_col_out,
  output logic [idx_w(N)-1:0]    x_read_row_addr,
  output logic [idx_w(M)-1:0]    x_read_col_addr,
  output logic                   x_read_ready,
  input  logic                   x_read_valid,
  input  logic [WIDTH-1:0]       x_read_data,
  output logic [idx_w(N)-1:0]    x_write_row_addr,
  output logic [idx_w(M)-1:0]    x_write_col_addr,
  output logic [WIDTH-1:0]       x_write_data,
  output logic                   x_write_ready,
  output logic [K*WIDTH-1:0]     dot_product_a,
  output logic [K*WIDTH-1:0]     dot_product_b,
  output logic [WIDTH-1:0]       dot_product_c,
  output logic [K-1:0]           dot_product_enable,
  output logic                   dot_product_mode,
  output logic                   vector_mult_alu_ready,
  input  logic                   dot_product_valid,
  input  logic [WIDTH-1:0]       dot_product_out
);

  localparam int T  = ceil_div(P, K);
  localparam int IW = idx_w(N);
  localparam int JW = idx_w(M);
  localparam int TW = idx_w(T);

  mmac_state_t state;

  logic          mode;
  logic          req;
  logic          a_got;
  logic          b_got;
  logic          x_got;
  logic [IW-1:0] i;
  logic [JW-1:0] j;
  logic [TW-1:0] t;
  logic          i_last;
  logic          j_last;
  logic          t_last;
  logic          need_a;
  logic          fetched;
  logic          start_ok;
  logic          enter;
  logic          alu_hit;
  logic          wr;
  logic          wr_last;

  logic [WIDTH-1:0]   acc;
  logic [P*WIDTH-1:0] a_row;
  logic [P*WIDTH-1:0] b_col;
  logic [K-1:0]       en_a;
  logic [K-1:0]       en_b;

  assign need_a   = (j == '0);
  assign fetched  = (a_got | ~need_a) & b_got & (x_got | ~mode);
  assign start_ok = (state == IDLE) & start;
  assign alu_hit  = (state == WAIT) & dot_product_valid;
  assign wr       = (state == WRITE);
  assign wr_last  = i_last & j_last;
  assign enter    = start_ok | (wr & ~wr_last);

  counter_mod #(.MOD(N)) u_i (
    .clk   (clk),
    .rst   (rst),
    .clr   (start_ok),
    .inc   (wr & j_last),
    .count (i),
    .last  (i_last)
  );

  counter_mod #(.MOD(M)) u_j (
    .clk   (clk),
    .rst   (rst),
    .clr   (start_ok),
    .inc   (wr),
    .count (j),
    .last  (j_last)
  );

  counter_mod #(.MOD(T)) u_t (
    .clk   (clk),
    .rst   (rst),
    .clr   (start_ok),
    .inc   (alu_hit),
    .count (t),
    .last  (t_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mode  <= 1'b0;
      req   <= 1'b0;
      a_got <= 1'b0;
      b_got <= 1'b0;
      x_got <= 1'b0;
      acc   <= '0;
    end else begin
      // Every element starts from fresh flags and a zero addend.
      if (enter) begin
        req   <= 1'b1;
        a_got <= 1'b0;
        b_got <= 1'b0;
        x_got <= 1'b0;
        acc   <= '0;
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            mode  <= accumulate;
            state <= FETCH;
          end
        end
        FETCH: begin
          req <= 1'b0;
          if (a_row_valid && need_a && !a_got) a_got <= 1'b1;
          if (b_col_valid && !b_got) b_got <= 1'b1;
          if (x_read_valid && mode && !x_got) begin
            x_got <= 1'b1;
            acc   <= x_read_data;
          end
          if (fetched) state <= ISSUE;
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (dot_product_valid) begin
            acc   <= dot_product_out;
            state <= t_last ? WRITE : ISSUE;
          end
        end
        WRITE: state <= wr_last ? DONE : FETCH;
        DONE:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Operand buffers carry no reset; the flags decide when they are valid.
  always_ff @(posedge clk) begin
    if (state == FETCH && a_row_valid && need_a && !a_got) a_row <= a_row_out;
    if (state == FETCH && b_col_valid && !b_got) b_col <= b_col_out;
  end

  vector_chunk_select #(.P(P), .K(K), .WIDTH(WIDTH)) u_sel_a (
    .vec    (a_row),
    .t      (t),
    .chunk  (dot_product_a),
    .enable (en_a)
  );

  vector_chunk_select #(.P(P), .K(K), .WIDTH(WIDTH)) u_sel_b (
    .vec    (b_col),
    .t      (t),
    .chunk  (dot_product_b),
    .enable (en_b)
  );

  assign dot_product_enable    = en_a & en_b;
  assign dot_product_c         = acc;
  assign dot_product_mode      = 1'b1;
  assign vector_mult_alu_ready = (state == ISSUE);

  assign busy     = (state != IDLE);
  assign finished = (state == DONE);

  assign a_row_addr       = i;
  assign b_col_addr       = j;
  assign x_read_row_addr  = i;
  assign x_read_col_addr  = j;
  assign x_write_row_addr = i;
  assign x_write_col_addr = j;
  assign x_write_data     = acc;

  assign a_row_addr_ready = (state == FETCH) & req & need_a;
  assign b_col_addr_ready = (state == FETCH) & req;
  assign x_read_ready     = (state == FETCH) & req & mode;
  assign x_write_ready    = wr;

endmodule

// File: tb/tb_matrix_mac_tiled.sv
// Scoreboard bench: memory and ALU responders with random latency,
// expected X computed as a plain matrix product in modulo-2^32 integers.
module tb_matrix_mac_tiled;

  localparam int N = 3;
  localparam int P = 5;
  localparam int M = 2;
  localparam int K = 2;
  localparam int W = 32;
  localparam int T = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic           accumulate = 1'b0;
  logic           busy;
  logic           finished;
  logic [1:0]     a_row_addr;
  logic           a_row_addr_ready;
  logic           a_row_valid = 1'b0;
  logic [P*W-1:0] a_row_out = '0;
  logic [0:0]     b_col_addr;
  logic           b_col_addr_ready;
  logic           b_col_valid = 1'b0;
  logic [P*W-1:0] b_col_out = '0;
  logic [1:0]     x_read_row_addr;
  logic [0:0]     x_read_col_addr;
  logic           x_read_ready;
  logic           x_read_valid = 1'b0;
  logic [W-1:0]   x_read_data = '0;
  logic [1:0]     x_write_row_addr;
  logic [0:0]     x_write_col_addr;
  logic [W-1:0]   x_write_data;
  logic           x_write_ready;
  logic [K*W-1:0] dot_product_a;
  logic [K*W-1:0] dot_product_b;
  logic [W-1:0]   dot_product_c;
  logic [K-1:0]   dot_product_enable;
  logic           dot_product_mode;
  logic           vector_mult_alu_ready;
  logic           dot_product_valid = 1'b0;
  logic [W-1:0]   dot_product_out = '0;

  always #5 clk = ~clk;

  matrix_mac_tiled #(.N(N), .P(P), .M(M), .K(K), .WIDTH(W)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .start                 (start),
    .accumulate            (accumulate),
    .busy                  (busy),
    .finished              (finished),
    .a_row_addr            (a_row_addr),
    .a_row_addr_ready      (a_row_addr_ready),
    .a_row_valid           (a_row_valid),
    .a_row_out             (a_row_out),
    .b_col_addr            (b_col_addr),
    .b_col_addr_ready      (b_col_addr_ready),
    .b_col_valid           (b_col_valid),
    .b_col_out             (b_col_out),
    .x_read_row_addr       (x_read_row_addr),
    .x_read_col_addr       (x_read_col_addr),
    .x_read_ready          (x_read_ready),
    .x_read_valid          (x_read_valid),
    .x_read_data           (x_read_data),
    .x_write_row_addr      (x_write_row_addr),
    .x_write_col_addr      (x_write_col_addr),
    .x_write_data          (x_write_data),
    .x_write_ready         (x_write_ready),
    .dot_product_a         (dot_product_a),
    .dot_product_b         (dot_product_b),
    .dot_product_c         (dot_product_c),
    .dot_product_enable    (dot_product_enable),
    .dot_product_mode      (dot_product_mode),
    .vector_mult_alu_ready (vector_mult_alu_ready),
    .dot_product_valid     (dot_product_valid),
    .dot_product_out       (dot_product_out)
  );

  typedef struct {
    int          row;
    int          col;
    logic [31:0] val;
  } exp_t;

  logic [31:0] amem [N][P];
  logic [31:0] bmem [P][M];
  logic [31:0] xmem [N][M];
  exp_t        exp_q [$];

  int checks = 0;
  int failures = 0;
  int wr_count = 0;
  int fin_count = 0;
  int xr_count = 0;
  int issue_idx = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // A memory: row response after 0-7 cycles.
  initial begin : a_mem
    int r;
    forever begin
      @(negedge clk);
      a_row_valid = 1'b0;
      if (a_row_addr_ready) begin
        r = int'(a_row_addr);
        repeat ($urandom_range(0, 7)) @(negedge clk);
        for (int p = 0; p < P; p++) a_row_out[p*W +: W] = amem[r][p];
        a_row_valid = 1'b1;
      end
    end
  end

  // B memory: column response after 0-7 cycles, skewed from A.
  initial begin : b_mem
    int c;
    forever begin
      @(negedge clk);
      b_col_valid = 1'b0;
      if (b_col_addr_ready) begin
        c = int'(b_col_addr);
        repeat ($urandom_range(0, 7)) @(negedge clk);
        for (int p = 0; p < P; p++) b_col_out[p*W +: W] = bmem[p][c];
        b_col_valid = 1'b1;
      end
    end
  end

  initial begin : x_mem
    int r;
    int c;
    forever begin
      @(negedge clk);
      x_read_valid = 1'b0;
      if (x_read_ready) begin
        xr_count++;
        r = int'(x_read_row_addr);
        c = int'(x_read_col_addr);
        repeat ($urandom_range(0, 7)) @(negedge clk);
        x_read_data  = xmem[r][c];
        x_read_valid = 1'b1;
      end
    end
  end

  // ALU: a.b + c over enabled lanes, latency 1-9, junk valids in FETCH.
  initial begin : alu
    logic [31:0] res;
    logic [K-1:0] en_req;
    bit tail;
    forever begin
      @(negedge clk);
      dot_product_valid = 1'b0;
      if (vector_mult_alu_ready) begin
        tail = (issue_idx % T) == T - 1;
        en_req = tail ? 2'b01 : 2'b11;
        chk("issue_enable", 64'(dot_product_enable), 64'(en_req));
        chk("issue_mode", 64'(dot_product_mode), 64'(1));
        if (tail) begin
          chk("tail_lane1_zero",
              {dot_product_a[2*W-1:W], dot_product_b[2*W-1:W]}, 64'(0));
        end
        issue_idx++;
        res = dot_product_c;
        for (int l = 0; l < K; l++) begin
          if (dot_product_enable[l]) begin
            res = res + dot_product_a[l*W +: W] * dot_product_b[l*W +: W];
          end
        end
        repeat ($urandom_range(1, 9)) @(negedge clk);
        dot_product_out   = res;
        dot_product_valid = 1'b1;
      end else if (b_col_addr_ready && $urandom_range(0, 1) == 1) begin
        dot_product_out   = 32'hdead_beef;
        dot_product_valid = 1'b1;
      end
    end
  end

  initial begin : monitor
    exp_t e;
    bit fin_prev;
    fin_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (x_write_ready) begin
        wr_count++;
        chk("write_expected", 64'(exp_q.size() > 0), 64'(1));
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("write_row", 64'(x_write_row_addr), 64'(e.row));
          chk("write_col", 64'(x_write_col_addr), 64'(e.col));
          chk("write_data", 64'(x_write_data), 64'(e.val));
        end
        xmem[x_write_row_addr][x_write_col_addr] = x_write_data;
      end
      if (fin_prev) chk("finished_width", 64'(finished), 64'(0));
      if (finished) fin_count++;
      fin_prev = finished;
    end
  end

  task automatic run_job(input bit mode, input bit repulse);
    logic [31:0] v;
    int wr0;
    int f0;
    int x0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < M; j++) begin
        v = mode ? xmem[i][j] : 32'd0;
        for (int p = 0; p < P; p++) v = v + amem[i][p] * bmem[p][j];
        exp_q.push_back('{row: i, col: j, val: v});
      end
    end
    wr0 = wr_count;
    f0 = fin_count;
    x0 = xr_count;
    issue_idx = 0;
    @(negedge clk);
    start = 1'b1;
    accumulate = mode;
    @(negedge clk);
    start = 1'b0;
    accumulate = ~mode;
    if (repulse) begin
      repeat (20) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int c = 0; c < 4000 && fin_count == f0; c++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("job_finished_once", 64'(fin_count - f0), 64'(1));
    chk("write_count", 64'(wr_count - wr0), 64'(N * M));
    chk("xread_count", 64'(xr_count - x0), 64'(mode ? N * M : 0));
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    chk("idle_after_job", 64'(busy), 64'(0));
    if (exp_q.size() > 0) exp_q.delete();
  endtask

  task automatic load_directed();
    logic [31:0] a_init [N][P];
    logic [31:0] b_init [P][M];
    a_init = '{'{1, 2, 3, 0, 0}, '{4, 5, 6, 0, 0}, '{7, 8, 9, 1, 2}};
    b_init = '{'{1, 0}, '{0, 1}, '{1, 1}, '{2, 3}, '{5, 7}};
    amem = a_init;
    bmem = b_init;
  endtask

  task automatic load_random();
    for (int i = 0; i < N; i++)
      for (int p = 0; p < P; p++) amem[i][p] = $urandom;
    for (int p = 0; p < P; p++)
      for (int j = 0; j < M; j++) bmem[p][j] = $urandom;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < M; j++) xmem[i][j] = $urandom;
  endtask

  initial begin : stim
    int alu_seen;
    int wr0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < M; j++) xmem[i][j] = 32'd0;

    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_finished", 64'(finished), 64'(0));
    chk("rst_a_ready", 64'(a_row_addr_ready), 64'(0));
    chk("rst_b_ready", 64'(b_col_addr_ready), 64'(0));
    chk("rst_x_rd_ready", 64'(x_read_ready), 64'(0));
    chk("rst_x_wr_ready", 64'(x_write_ready), 64'(0));
    chk("rst_alu_ready", 64'(vector_mult_alu_ready), 64'(0));
    chk("rst_addr", 64'({a_row_addr, b_col_addr, x_write_row_addr}), 64'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    load_directed();
    run_job(1'b0, 1'b0);
    chk("dir_x00", 64'(xmem[0][0]), 64'(4));
    chk("dir_x01", 64'(xmem[0][1]), 64'(5));
    chk("dir_x10", 64'(xmem[1][0]), 64'(10));
    chk("dir_x11", 64'(xmem[1][1]), 64'(11));

    for (int i = 0; i < N; i++)
      for (int j = 0; j < M; j++) xmem[i][j] = 32'd1;
    run_job(1'b1, 1'b0);
    chk("acc_x00", 64'(xmem[0][0]), 64'(5));
    chk("acc_x01", 64'(xmem[0][1]), 64'(6));
    chk("acc_x10", 64'(xmem[1][0]), 64'(11));
    chk("acc_x11", 64'(xmem[1][1]), 64'(12));

    for (int r = 0; r < 4; r++) begin
      load_random();
      run_job(1'($urandom_range(0, 1)), r == 1);
    end

    // Reset while the ALU is working on the second chunk.
    load_random();
    wr0 = wr_count;
    issue_idx = 0;
    @(negedge clk);
    start = 1'b1;
    accumulate = 1'b1;
    @(negedge clk);
    start = 1'b0;
    alu_seen = 0;
    for (int c = 0; c < 400 && alu_seen < 2; c++) begin
      @(negedge clk);
      if (vector_mult_alu_ready) alu_seen++;
    end
    chk("rst_test_reached_wait", 64'(alu_seen), 64'(2));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midjob_rst_busy", 64'(busy), 64'(0));
    repeat (25) @(negedge clk);
    chk("midjob_rst_no_write", 64'(wr_count - wr0), 64'(0));
    chk("midjob_rst_idle", 64'(busy), 64'(0));

    load_random();
    run_job(1'b1, 1'b0);
    load_random();
    run_job(1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
